mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read memory; each transfer runs IDLE->ADDR->WAIT->ACK.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [15:0]   m0_wdata,
    output logic          m0_ack,
    output logic [15:0]   m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [15:0]   m1_wdata,
    output logic          m1_ack,
    output logic [15:0]   m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          mem_wr,
    input  logic [15:0]   mem_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, ACK} state_t;

    state_t state, state_nxt;
    logic   grant_sel;  // 1 selects port 1
    logic   owner;
    logic   xfer_wr;
`ifdef ARB_ROUND_ROBIN_EN
    logic   last_owner;
`endif

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m0_req && m1_req) grant_sel = ~last_owner;
        else                  grant_sel = m1_req;
`else
        grant_sel = ~m0_req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_nxt = ADDR;
            ADDR:    state_nxt = WAIT;
            WAIT:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transfer attributes are latched at grant so requesters may change inputs afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            xfer_wr   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wr    <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            mem_wr <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner     <= grant_sel;
                        xfer_wr   <= grant_sel ? m1_wr : m0_wr;
                        mem_wr    <= grant_sel ? m1_wr : m0_wr;
                        mem_addr  <= grant_sel ? m1_addr : m0_addr;
                        mem_wdata <= grant_sel ? m1_wdata : m0_wdata;
                    end
                end
                WAIT: begin
                    if (!xfer_wr) begin
                        if (owner) m1_rdata <= mem_rdata;
                        else       m0_rdata <= mem_rdata;
                    end
                    if (owner) m1_ack <= 1'b1;
                    else       m0_ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            last_owner <= 1'b1;
        else if (state == IDLE && (m0_req || m1_req)) last_owner <= grant_sel;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed latency/reset/contention cases plus random traffic
// checked against a transaction-level memory and arbitration-rule model.
module tb_mem_arbiter;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [15:0]   m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [15:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_wr;
    logic [15:0]   mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 16'hBEEF;
        return {a ^ 8'h5A, ~a};
    endfunction

    // Synchronous-read memory attached to the shared port
    logic [15:0] mem [256];
    bit   [255:0] mem_wrote;
    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr[7:0]]       <= mem_wdata;
            mem_wrote[mem_addr[7:0]] <= 1'b1;
        end
        mem_rdata <= mem_wrote[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);
    end

    // Request history per rising edge, used to check who was eligible at each grant
    int cyc = 0;
    bit h0 [1024];
    bit h1 [1024];
    always @(posedge clk) begin
        cyc = cyc + 1;
        h0[cyc % 1024] = m0_req;
        h1[cyc % 1024] = m1_req;
    end

    // Current transaction of each port, as issued by the stimulus
    logic          t_wr    [2];
    logic [AW-1:0] t_addr  [2];
    logic [15:0]   t_wdata [2];

    // Reference model: shadow memory updated in ack order, expected rdata per port
    logic [15:0] ref_mem [256];
    bit   [255:0] ref_wrote;
    logic [15:0] exp_rd0, exp_rd1, ev;
    int          last_own, last_ack_cyc, mp, mg;
    logic [7:0]  ma;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_rd0      = '0;
            exp_rd1      = '0;
            last_own     = 1;
            last_ack_cyc = -100;
        end else if (m0_ack || m1_ack) begin
            mp = m1_ack ? 1 : 0;
            mg = (cyc - 2) % 1024;
            chk("ack_onehot", 32'(m0_ack && m1_ack), 32'(0));
            chk("ack_spacing", 32'(cyc - last_ack_cyc >= 4), 32'(1));
            chk("owner_requested", 32'(mp ? h1[mg] : h0[mg]), 32'(1));
`ifdef ARB_ROUND_ROBIN_EN
            if (h0[mg] && h1[mg]) chk("rr_alternate", 32'(mp), 32'(1 - last_own));
`else
            chk("fixed_priority", 32'(mp == 1 && h0[mg]), 32'(0));
`endif
            ma = t_addr[mp][7:0];
            if (t_wr[mp]) begin
                ref_mem[ma]   = t_wdata[mp];
                ref_wrote[ma] = 1'b1;
            end else begin
                ev = ref_wrote[ma] ? ref_mem[ma] : init_val(ma);
                if (mp == 1) exp_rd1 = ev;
                else         exp_rd0 = ev;
            end
            chk("m0_rdata", 32'(m0_rdata), 32'(exp_rd0));
            chk("m1_rdata", 32'(m1_rdata), 32'(exp_rd1));
            last_own     = mp;
            last_ack_cyc = cyc;
        end
    end

    task automatic set_port(input int p, input logic req, input logic wr,
                            input logic [AW-1:0] addr, input logic [15:0] wdata);
        if (p == 0) begin
            m0_req = req; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic issue(input int p, input logic wr, input logic [AW-1:0] addr, input logic [15:0] wdata);
        t_wr[p] = wr; t_addr[p] = addr; t_wdata[p] = wdata;
        set_port(p, 1'b1, wr, addr, wdata);
    endtask

    task automatic wait_ack(input int p, input int limit, output int n);
        bit got;
        got = 1'b0;
        n = 0;
        while (!got && n < limit) begin
            @(negedge clk);
            n++;
            got = (p == 1) ? m1_ack : m0_ack;
        end
        chk("ack_within_bound", 32'(got), 32'(1));
    endtask

    // Single transfer on an idle arbiter with cycle-exact checks; drop=1 releases req in ADDR
    task automatic do_xfer(input int p, input logic wr, input logic [AW-1:0] addr,
                           input logic [15:0] wdata, input bit drop);
        @(negedge clk);
        issue(p, wr, addr, wdata);
        @(negedge clk);
        chk("addr_at_n1", 32'(mem_addr), 32'(addr));
        chk("wr_at_n1", 32'(mem_wr), 32'(wr));
        if (wr) chk("wdata_at_n1", 32'(mem_wdata), 32'(wdata));
        if (drop) set_port(p, 1'b0, ~wr, addr ^ 16'h00FF, ~wdata);
        @(negedge clk);
        chk("wr_off_n2", 32'(mem_wr), 32'(0));
        chk("ack_early", 32'(m0_ack | m1_ack), 32'(0));
        @(negedge clk);
        chk("own_ack_n3", 32'(p ? m1_ack : m0_ack), 32'(1));
        chk("other_ack_n3", 32'(p ? m0_ack : m1_ack), 32'(0));
        set_port(p, 1'b0, wr, addr, wdata);
        @(negedge clk);
        chk("ack_one_cycle", 32'(m0_ack | m1_ack), 32'(0));
        chk("addr_hold", 32'(mem_addr), 32'(addr));
    endtask

    task automatic rand_driver(input int p, input int ntx);
        int            idle, n;
        logic          wr;
        logic [AW-1:0] a;
        logic [15:0]   d;
        for (int i = 0; i < ntx; i++) begin
            idle = $urandom_range(6, 1);
            repeat (idle) @(negedge clk);
            wr = 1'($urandom_range(1, 0));
            a  = AW'($urandom_range(31, 0));
            d  = 16'($urandom);
            issue(p, wr, a, d);
            wait_ack(p, 300, n);
            set_port(p, 1'b0, wr, a, d);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(0));
        chk({tag, "_mem_wr"}, 32'(mem_wr), 32'(0));
        chk({tag, "_m0_ack"}, 32'(m0_ack), 32'(0));
        chk({tag, "_m1_ack"}, 32'(m1_ack), 32'(0));
        chk({tag, "_m0_rdata"}, 32'(m0_rdata), 32'(0));
        chk({tag, "_m1_rdata"}, 32'(m1_rdata), 32'(0));
    endtask

    initial begin
        int          n, k;
        logic [15:0] prev;
        int          seq [4];
        rst_n = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            t_wr[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Port 0 read of preloaded 0xBEEF
        do_xfer(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("read_beef", 32'(m0_rdata), 32'(16'hBEEF));

        // Port 1 write, then read back through port 0
        prev = m1_rdata;
        do_xfer(1, 1'b1, 16'h0020, 16'h1234, 1'b0);
        chk("write_keeps_rdata", 32'(m1_rdata), 32'(prev));
        do_xfer(0, 1'b0, 16'h0020, 16'h0000, 1'b0);
        chk("readback_1234", 32'(m0_rdata), 32'(16'h1234));

        // Request dropped and inputs changed during ADDR still completes
        do_xfer(0, 1'b0, 16'h0007, 16'h0000, 1'b1);
        do_xfer(1, 1'b1, 16'h0003, 16'hA5C3, 1'b1);

        // Request held past ack starts a new transfer four cycles later
        @(negedge clk);
        issue(0, 1'b0, 16'h0003, 16'h0000);
        wait_ack(0, 10, n);
        chk("first_latency", 32'(n), 32'(3));
        wait_ack(0, 10, n);
        chk("rereq_gap", 32'(n), 32'(4));
        set_port(0, 1'b0, 1'b0, 16'h0003, 16'h0000);
        @(negedge clk);

        // Reset during WAIT of a port 0 read
        @(negedge clk);
        issue(0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        set_port(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) k++;
        end
        chk("no_ack_after_reset", 32'(k), 32'(0));
        do_xfer(0, 1'b0, 16'h0010, 16'h0000, 1'b0);
        chk("read_after_reset", 32'(m0_rdata), 32'(16'hBEEF));

        // Continuous contention from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 16'h0010, 16'h0000);
        issue(1, 1'b0, 16'h0020, 16'h0000);
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                seq[k] = m1_ack ? 1 : 0;
                k++;
            end
        end
        set_port(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
        set_port(1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        chk("contend_acks", 32'(k), 32'(4));
        for (int i = 0; i < k; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk("contend_order", 32'(seq[i]), 32'(i % 2));
`else
            chk("contend_order", 32'(seq[i]), 32'(0));
`endif
        end
        repeat (2) @(negedge clk);

        // Random traffic on both ports
        fork
            rand_driver(0, 40);
            rand_driver(1, 40);
        join
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
